// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> 32-bit IM writes, holds CPU while loading.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  output logic              RX_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [31:0]       W_Ins,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);
  localparam int NW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } state_t;

  state_t        state;
  logic [7:0]    len_hi;
  logic [NW-1:0] nwords;
  logic [NW-1:0] widx;
  logic [NW-1:0] widx_inc;
  logic [1:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [15:0]   len_n;
  logic [31:0]   nxt_word;
  logic          xfer;
  logic          waiting;
  logic          tmo;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    chk;
`endif

  assign xfer     = RX_VALID & RX_READY;
  assign len_n    = {len_hi, RX_DATA};
  assign widx_inc = widx + NW'(1);
  assign W_ADDR   = widx[ADDR_W-1:0];
  // The word is assembled in place in W_Ins; only its WRITE-cycle value matters.
  assign nxt_word = BIG_ENDIAN ? {W_Ins[23:0], RX_DATA}
                               : {RX_DATA, W_Ins[31:8]};

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign waiting = state inside {S_LEN_H, S_LEN_L, S_DATA, S_CHK};
`else
  assign waiting = state inside {S_LEN_H, S_LEN_L, S_DATA};
`endif
  assign tmo = waiting & ~xfer & (tcnt == TMAX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      RX_READY <= 1'b0;
      WE       <= 1'b0;
      W_Ins    <= '0;
      CPU_HOLD <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      len_hi   <= '0;
      nwords   <= '0;
      widx     <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      WE   <= 1'b0;
      DONE <= 1'b0;
      tcnt <= (waiting && !xfer) ? tcnt + TW'(1) : '0;
      if (tmo) begin
        state    <= S_IDLE;
        RX_READY <= 1'b1;
        ERR      <= 1'b1;
        CPU_HOLD <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            RX_READY <= 1'b1;
            if (xfer && RX_DATA == 8'hA5) begin
              state    <= S_LEN_H;
              CPU_HOLD <= 1'b1;
              ERR      <= 1'b0;
            end
          end
          S_LEN_H: begin
            if (xfer) begin
              len_hi <= RX_DATA;
              state  <= S_LEN_L;
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk    <= RX_DATA;
`endif
            end
          end
          S_LEN_L: begin
            if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk <= chk ^ RX_DATA;
`endif
              if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state    <= S_CHK;
`else
                state    <= S_FIN;
                RX_READY <= 1'b0;
                DONE     <= 1'b1;
`endif
              end else if (32'(len_n) > DEPTH) begin
                state    <= S_IDLE;
                ERR      <= 1'b1;
                CPU_HOLD <= 1'b0;
              end else begin
                state  <= S_DATA;
                widx   <= '0;
                bcnt   <= '0;
                nwords <= NW'(len_n);
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              W_Ins <= nxt_word;
              bcnt  <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
              chk   <= chk ^ RX_DATA;
`endif
              if (bcnt == 2'd3) begin
                state    <= S_WRITE;
                WE       <= 1'b1;
                RX_READY <= 1'b0;
              end
            end
          end
          S_WRITE: begin
            widx <= widx_inc;
            if (widx_inc == nwords) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
              RX_READY <= 1'b1;
`else
              state    <= S_FIN;
              DONE     <= 1'b1;
`endif
            end else begin
              state    <= S_DATA;
              RX_READY <= 1'b1;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          S_CHK: begin
            if (xfer) begin
              if (RX_DATA == chk) begin
                state    <= S_FIN;
                RX_READY <= 1'b0;
                DONE     <= 1'b1;
              end else begin
                state    <= S_IDLE;
                ERR      <= 1'b1;
                CPU_HOLD <= 1'b0;
              end
            end
          end
`endif
          S_FIN: begin
            state    <= S_IDLE;
            CPU_HOLD <= 1'b0;
            RX_READY <= 1'b1;
          end
          default: begin
            state    <= S_IDLE;
            RX_READY <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
